param_sync_fifo: RTL and testbench
==================================

# param_sync_fifo

Parametrised single-clock FIFO and the next-generation replacement for the fixed 32×16 buffer. It generalises width and depth and adds registered occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags with clear, and compile-time first-word-fall-through mode. All status flags are active-high. It sits between a producer and a consumer in the same clock domain.

## Interface
- WIDTH, 32, data width in bits (≥1)
- DEPTH, 16, number of entries; power of 2, ≥4
- AFULL_THRESH, DEPTH-2, almost_full asserted when count ≥ AFULL_THRESH
- AEMPTY_THRESH, 2, almost_empty asserted when count ≤ AEMPTY_THRESH
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data
- rd_en  in  1  read (pop) request
- rd_data  out  WIDTH  read data
- rd_valid  out  1  rd_data holds valid popped/head data
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- almost_full  out  1  count ≥ AFULL_THRESH
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow and underflow

## Operation
- Read and write pointers are AW+1 bits wide, where AW = $clog2(DEPTH). The low AW bits address storage. The MSB disambiguates full from empty on wrap. count = wr_ptr − rd_ptr, modulo 2^(AW+1).
- Read accept: rd_en && !empty. Each accepted read increments rd_ptr.
- Write accept: wr_en && (!full || rd_accept). A write to a full FIFO with a simultaneous accepted read is accepted, and count stays at DEPTH.
- Simultaneous read and write on an empty FIFO: the write is accepted, the read is rejected, and underflow is set.
- A rejected write drops its data and sets overflow. A rejected read sets underflow. Pointers are unchanged in both cases.
- overflow and underflow hold until clr_err or rst. If clr_err coincides with a new error in the same cycle, the error wins and the flag stays set.
- Pointers wrap naturally at 2^(AW+1). There is no special case for wrap.
- Storage contents are not reset.

## Timing
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rd_valid=0, rd_data=0.
- rst asserted mid-operation discards all contents on the next edge. Requests in that cycle are ignored, and no error flags are set.
- count and all four flags are combinational from the registered pointers only. They update the cycle after an accepted edge.
- Standard mode (read latency 1):
  - A read accepted at edge N presents data on rd_data, with rd_valid=1, after edge N.
  - rd_valid is high for exactly one cycle per accepted read.
  - rd_data holds its last value otherwise.
- Write-to-read latency: data written at edge N is readable by a rd_en sampled at edge N+1.

## Configuration
- PARAM_SYNC_FIFO_FWFT_EN defined (first-word fall-through):
  - rd_data always shows the head entry, and rd_valid = !empty.
  - rd_en pops the head; the next entry is visible after that edge.
  - A write to an empty FIFO at edge N gives rd_valid=1 after edge N.
  - Read latency is 0.
- PARAM_SYNC_FIFO_FWFT_EN undefined: standard registered-read behaviour as given under Timing.
- Accept rules, count, flags and error behaviour are identical in both modes.

## Structure
- Package param_fifo_pkg contains:
  - the clog2-based width helper function;
  - elaboration-time checks: DEPTH is a power of 2 and ≥4; 0 < AEMPTY_THRESH < AFULL_THRESH < DEPTH;
  - typedef fifo_err_t, a packed struct {overflow, underflow}.
- Sub-module fifo_mem_2p: simple dual-port array with synchronous write and asynchronous read port. The parent registers read data in standard mode.

## Test plan
- WIDTH=32, DEPTH=16: after rst, write 0x0..0xF in 16 cycles, then read 16 → rd_data returns 0x0..0xF in order; full=1 after the 16th write; empty=1 after the 16th read.
- Write 14 words → almost_full=1 when count=14. Read down to 2 → almost_empty=1. count tracks every step.
- Fill to 16, then wr_en=1 with 0xDEAD → overflow=1, count=16, and 0xDEAD never appears. Pulse clr_err → overflow=0.
- Empty FIFO with rd_en=1 and wr_en=1 (0xA5) together → underflow=1, count=1. The next read returns 0xA5.
- Full FIFO with simultaneous rd_en and wr_en for 40 cycles → count stays 16, data stays in order across pointer wrap, and no overflow is flagged.
- With PARAM_SYNC_FIFO_FWFT_EN defined: write 0x55 into an empty FIFO → rd_valid=1 and rd_data=0x55 the next cycle, with no rd_en. Assert rst mid-stream → empty=1 and rd_valid=0 next cycle.

Source files
------------

// File: rtl/param_sync_fifo_pkg.sv
// Shared types and elaboration helpers for param_sync_fifo (package param_fifo_pkg).
// Covers the storage address width, the configuration legality checks and the
// packed error-flag record.
package param_fifo_pkg;

  // Sticky error flags held by the FIFO.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // Storage address width for a given depth. Never returns zero, so vectors
  // sized from it always exist.
  function automatic int fifo_addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // The depth must be a power of two so the pointers wrap naturally, and it
  // must be at least four.
  function automatic bit fifo_depth_ok(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

  // The thresholds must be strictly ordered inside the occupancy range.
  function automatic bit fifo_thresh_ok(input int depth, input int aempty, input int afull);
    return (aempty > 0) && (aempty < afull) && (afull < depth);
  endfunction

endpackage

// File: rtl/param_sync_fifo_mem_2p.sv
// fifo_mem_2p: simple dual-port storage for param_sync_fifo.
// It has one synchronous write port and one asynchronous read port.
// The contents are never reset.
module fifo_mem_2p
  import param_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = fifo_addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: the entry is updated on the clock edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read port: combinational from the address.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO.
// - Occupancy count and status flags are decoded from the registered pointers.
// - Overflow and underflow are sticky error flags, cleared by clr_err.
// - Optional first-word fall-through mode: define PARAM_SYNC_FIFO_FWFT_EN.
//   When it is undefined, reads have one cycle of latency.
module param_sync_fifo
  import param_fifo_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam int          AW        = fifo_addr_w(DEPTH);
  localparam int          PW        = AW + 1;
  localparam logic [AW:0] DEPTH_C   = PW'(DEPTH);
  localparam logic [AW:0] AFULL_C   = PW'(AFULL_THRESH);
  localparam logic [AW:0] AEMPTY_C  = PW'(AEMPTY_THRESH);

  if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of 2 and >= 4");
  end
  if (!fifo_thresh_ok(DEPTH, AEMPTY_THRESH, AFULL_THRESH)) begin : g_bad_thresh
    $error("param_sync_fifo: need 0 < AEMPTY_THRESH < AFULL_THRESH < DEPTH");
  end

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  fifo_err_t        err_q, err_d;
  logic             rd_accept;
  logic             wr_accept;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rd_data;

  // The pointer difference wraps modulo 2^(AW+1). That is enough to tell
  // full apart from empty.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AEMPTY_C);
  assign almost_full  = (count >= AFULL_C);
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

  // Accept decisions. A full FIFO still takes a write if a pop happens in the
  // same cycle. An empty FIFO never pops, even if a write is arriving.
  always_comb begin
    rd_accept = rd_en && !empty;
    wr_accept = wr_en && (!full || rd_accept);
    mem_we    = wr_accept && !rst;
  end

  // Pointer and error-flag next state. Reset overrides everything. A new error
  // takes priority over clr_err in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    if (clr_err)   err_d    = '0;
    if (wr_en && !wr_accept) err_d.overflow  = 1'b1;
    if (rd_en && empty)      err_d.underflow = 1'b1;
    if (rst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      err_d    = '0;
    end
  end

  // Register the pointers and the sticky flags.
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    err_q    <= err_d;
  end

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (mem_rd_data)
  );

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  // The head entry is shown directly. The output is held at zero while the
  // FIFO is empty, so stale storage never shows.
  assign rd_data  = empty ? '0 : mem_rd_data;
  assign rd_valid = !empty;
`else
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  // Capture the head on an accepted pop. The last value is held otherwise.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_accept;
    if (rd_accept) rd_data_d = mem_rd_data;
    if (rst) begin
      rd_data_d  = '0;
      rd_valid_d = 1'b0;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rd_data_q  <= rd_data_d;
    rd_valid_q <= rd_valid_d;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed and random bench for param_sync_fifo (WIDTH=32, DEPTH=16).
// It covers both read modes, selected by PARAM_SYNC_FIFO_FWFT_EN.
module tb_param_sync_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_en = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [4:0]       count;
  logic             empty, full, almost_empty, almost_full, overflow, underflow;

  param_sync_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .empty(empty),
    .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of the stored words, plus the expected flags.
  logic [WIDTH-1:0] q[$];
  bit               m_ovf, m_unf, m_valid;
  logic [WIDTH-1:0] m_data;
  int               n_total = 0;
  int               n_pass  = 0;
  bit               dead_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"},  32'(count),        32'(n));
    chk({tag, ".empty"},  32'(empty),        32'(n == 0));
    chk({tag, ".full"},   32'(full),         32'(n == DEPTH));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AE));
    chk({tag, ".afull"},  32'(almost_full),  32'(n >= AF));
    chk({tag, ".ovf"},    32'(overflow),     32'(m_ovf));
    chk({tag, ".unf"},    32'(underflow),    32'(m_unf));
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    chk({tag, ".valid"},  32'(rd_valid),     32'(n != 0));
    chk({tag, ".data"},   rd_data,           (n != 0) ? q[0] : 32'h0);
`else
    chk({tag, ".valid"},  32'(rd_valid),     32'(m_valid));
    chk({tag, ".data"},   rd_data,           m_data);
`endif
  endtask

  // Drive one cycle, advance the model by the FIFO rules, then compare.
  task automatic step(input string tag, input bit r, input bit w,
                      input logic [WIDTH-1:0] wd, input bit rd, input bit clr);
    bit was_empty, was_full, racc, wacc;
    @(negedge clk);
    rst = r; wr_en = w; wr_data = wd; rd_en = rd; clr_err = clr;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_valid = 0; m_data = '0;
    end else begin
      was_empty = (q.size() == 0);
      was_full  = (q.size() == DEPTH);
      racc = rd && !was_empty;
      wacc = w && (!was_full || racc);
      m_valid = racc;
      if (racc) m_data = q.pop_front();
      if (wacc) q.push_back(wd);
      m_ovf = (m_ovf && !clr) || (w && !wacc);
      m_unf = (m_unf && !clr) || (rd && was_empty);
    end
    #1;
    if (rd_valid && rd_data === 32'hDEAD) dead_seen = 1;
    check_all(tag);
  endtask

  initial begin
    m_data = '0;
    step("rst", 1, 0, 0, 0, 0);
    step("rst", 1, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) step("fill", 0, 1, 32'(i), 0, 0);
    chk("full_after_16", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) step("drain", 0, 0, 0, 1, 0);
    step("drain_tail", 0, 0, 0, 0, 0);
    chk("empty_after_16", 32'(empty), 32'd1);

    for (int i = 0; i < 14; i++) step("to14", 0, 1, 32'h100 + 32'(i), 0, 0);
    chk("afull_at_14", 32'(almost_full), 32'd1);
    for (int i = 0; i < 12; i++) step("to2", 0, 0, 0, 1, 0);
    chk("aempty_at_2", 32'(almost_empty), 32'd1);

    for (int i = 0; i < 14; i++) step("to16", 0, 1, 32'h200 + 32'(i), 0, 0);
    step("ovf", 0, 1, 32'hDEAD, 0, 0);
    chk("ovf_count16", 32'(count), 32'd16);
    step("clr", 0, 0, 0, 0, 1);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    step("clr_vs_err", 0, 1, 32'hDEAD, 0, 1);
    chk("err_beats_clr", 32'(overflow), 32'd1);
    step("clr2", 0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) step("out", 0, 0, 0, 1, 0);

    step("empty_rw", 0, 1, 32'hA5, 1, 0);
    chk("unf_set", 32'(underflow), 32'd1);
    step("read_a5", 0, 0, 0, 1, 0);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    chk("a5_data", rd_data, 32'hA5);
`endif
    step("clr3", 0, 0, 0, 0, 1);

    for (int i = 0; i < 16; i++) step("fill2", 0, 1, 32'h300 + 32'(i), 0, 0);
    for (int i = 0; i < 40; i++) step("wrap", 0, 1, 32'h400 + 32'(i), 1, 0);
    chk("wrap_no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) step("drain2", 0, 0, 0, 1, 0);

    step("fw_55", 0, 1, 32'h55, 0, 0);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    chk("fwft_valid", 32'(rd_valid), 32'd1);
    chk("fwft_data", rd_data, 32'h55);
`endif
    step("mid", 0, 1, 32'h56, 0, 0);
    step("mid_rst", 1, 1, 32'h57, 1, 0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_no_unf", 32'(underflow), 32'd0);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)),
           $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    chk("dead_never_read", 32'(dead_seen), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
